wb_width_downsizer: RTL and testbench
=====================================

Name: wb_width_downsizer

Overview:
- Wishbone classic-cycle bridge: one wide master port (MST_DW) to one narrow slave port (SLV_DW); splits each master access into up to R = MST_DW/SLV_DW slave beats.
- Skips lane groups whose byte selects are all zero; assembles read data; returns a single ack/err/rty to the master.
- Sits between the 32-bit CPU/DMA bus and the 8/16-bit peripheral and legacy-memory segments.

Parameters:
- MST_DW, 32, master data width; multiple of SLV_DW; 16/32/64.
- SLV_DW, 8, slave data width; 8/16/32.
- ADDR_WIDTH, 32, byte address width on both ports.
- TMO_CYCLES, 255, watchdog limit in clocks; used only with WB_DS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m_adr_i  in  ADDR_WIDTH  master byte address; low log2(MST_DW/8) bits ignored.
- m_dat_i  in  MST_DW  master write data.
- m_dat_o  out  MST_DW  assembled read data.
- m_we_i  in  1  write enable.
- m_sel_i  in  MST_DW/8  byte selects.
- m_cyc_i, m_stb_i  in  1 each  cycle and strobe.
- m_ack_o, m_err_o, m_rty_o  out  1 each  termination, one-cycle pulses.
- s_adr_o  out  ADDR_WIDTH  slave byte address.
- s_dat_o  out  SLV_DW  slave write data.
- s_dat_i  in  SLV_DW  slave read data.
- s_we_o  out  1  write enable.
- s_sel_o  out  SLV_DW/8  slave byte selects.
- s_cyc_o, s_stb_o  out  1 each  cycle and strobe.
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination.

Behaviour:
- Reset (rst low, asynchronous): every output is 0, FSM is IDLE, data accumulator is cleared.
- Lane group k (0..R-1) covers m_sel_i[k*SB +: SB], where SB = SLV_DW/8. Ordering is little-endian, so group 0 holds the low bytes.
- Slave address for group k: {word base, 0} + k*SB.
- States: IDLE, REQ, DONE.
- IDLE, on m_cyc_i & m_stb_i: latch adr/we/sel/dat and compute the mask of non-zero groups.
  - Mask zero: go to DONE, which gives m_ack_o the next cycle with no slave access.
  - Otherwise: load the lowest set group and go to REQ.
- REQ: s_cyc_o = s_stb_o = 1; s_sel_o, s_dat_o and s_adr_o come from the current group; s_we_o is the latched we.
  - s_ack_i: write s_dat_i into accumulator slice k and clear mask bit k. Go to the next set group in the same REQ state, so s_stb_o stays high and the next beat goes out the following cycle. If no group remains, go to DONE.
  - s_err_i: abort the remaining groups; pulse m_err_o.
  - s_rty_i: abort; pulse m_rty_o. Groups already written are not rolled back.
  - More than one termination in the same cycle: priority is err > rty > ack.
- DONE: one-cycle m_ack_o, with m_dat_o valid in that cycle. Unselected lanes read 0. Go to IDLE. s_cyc_o is low in DONE.
- Latency: a master access with n selected groups and zero-wait slaves acks at cycle n+1 after the request cycle (n = 0 gives cycle 1).
- m_cyc_i dropped during REQ: s_cyc_o and s_stb_o drop the same cycle, FSM returns to IDLE, and no master termination is given.
- m_stb_i still high in the cycle after m_ack_o starts a new access. Back-to-back accesses are allowed.
- MST_DW == SLV_DW: R = 1, pure registered pass-through with one extra cycle of latency.
- Elaboration error if MST_DW % SLV_DW != 0.

Optional Feature:
- Macro WB_DS_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and on every s_ack_i, and increments each REQ cycle without a termination. When it reaches TMO_CYCLES: drop s_cyc_o/s_stb_o, pulse m_err_o, return to IDLE.
- Undefined: no counter; REQ waits for the slave indefinitely.

Test Plan:
- MST_DW=32, SLV_DW=8, read 0x1000, sel=4'hF, slave returns 0x11,0x22,0x33,0x44 with zero wait. Required: s_adr_o sequence 0x1000..0x1003, m_dat_o = 0x44332211, m_ack_o at cycle 5.
- Write 0x2000, dat=0xAABBCCDD, sel=4'b0101. Required: exactly two slave beats, at 0x2000 with 0xDD and at 0x2002 with 0xBB; m_ack_o once.
- sel=4'h0. Required: no s_cyc_o; m_ack_o one cycle after the request.
- SLV_DW=16, sel=4'hF, slave errs on the first beat. Required: m_err_o pulses, no second beat, m_ack_o stays 0.
- rst pulled low during REQ. Required: all outputs 0 immediately; the next access after release completes normally.
- WB_DS_TIMEOUT_EN defined, TMO_CYCLES=8, slave never terminates. Required: m_err_o after 8 REQ cycles and s_cyc_o deasserted.

Source files
------------

// File: rtl/wb_width_downsizer.sv
// rtl/wb_width_downsizer.sv - Wishbone wide-master to narrow-slave width bridge.
// Optional slave watchdog: define WB_DS_TIMEOUT_EN (limit TMO_CYCLES).
module wb_width_downsizer #(
  parameter int MST_DW     = 32,
  parameter int SLV_DW     = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [MST_DW-1:0]       m_dat_i,
  output logic [MST_DW-1:0]       m_dat_o,
  input  logic                    m_we_i,
  input  logic [MST_DW/8-1:0]     m_sel_i,
  input  logic                    m_cyc_i,
  input  logic                    m_stb_i,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  output logic                    m_rty_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [SLV_DW-1:0]       s_dat_o,
  input  logic [SLV_DW-1:0]       s_dat_i,
  output logic                    s_we_o,
  output logic [SLV_DW/8-1:0]     s_sel_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i
);

  localparam int R   = MST_DW / SLV_DW;
  localparam int SB  = SLV_DW / 8;
  localparam int MLB = $clog2(MST_DW / 8);
  localparam int SBL = $clog2(SB);
  localparam int IW  = (R > 1) ? $clog2(R) : 1;

  if (MST_DW % SLV_DW != 0) begin : g_bad_ratio
    $error("MST_DW must be a multiple of SLV_DW");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {T_ACK, T_ERR, T_RTY} term_t;

  state_t                    state_q, state_d;
  term_t                     term_q, term_d;
  logic [ADDR_WIDTH-1:MLB]   base_q;
  logic                      we_q;
  logic [MST_DW/8-1:0]       sel_q;
  logic [MST_DW-1:0]         dat_q;
  logic [MST_DW-1:0]         acc_q;
  logic [R-1:0]              mask_q, mask_d, req_mask, mask_left, cur_oh;
  logic [IW-1:0]             cur_q, cur_d;
  logic                      load, beat_ack, in_req;
  logic [MLB-1:0]            lane_off;
  logic                      unused_adr_low;

  assign unused_adr_low = ^m_adr_i[MLB-1:0];

  function automatic logic [IW-1:0] lowest(input logic [R-1:0] m);
    lowest = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (m[k]) lowest = IW'(k);
    end
  endfunction

  always_comb begin
    req_mask = '0;
    for (int k = 0; k < R; k++) begin
      req_mask[k] = |m_sel_i[k*SB +: SB];
    end
  end

  assign cur_oh    = R'(1) << cur_q;
  assign mask_left = mask_q & ~cur_oh;
  assign in_req    = (state_q == REQ);

`ifdef WB_DS_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_hit;

  assign tmo_hit = in_req && (tmo_cnt_q == TW'(TMO_CYCLES - 1));

  // Counts REQ cycles since entry or the last accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (!in_req || beat_ack) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  localparam int unused_tmo_cycles = TMO_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    term_d   = term_q;
    mask_d   = mask_q;
    cur_d    = cur_q;
    load     = 1'b0;
    beat_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          load   = 1'b1;
          mask_d = req_mask;
          term_d = T_ACK;
          if (req_mask == '0) begin
            state_d = DONE;
          end else begin
            cur_d   = lowest(req_mask);
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (s_err_i) begin
          term_d  = T_ERR;
          state_d = DONE;
        end else if (s_rty_i) begin
          term_d  = T_RTY;
          state_d = DONE;
        end else if (s_ack_i) begin
          beat_ack = 1'b1;
          mask_d   = mask_left;
          if (mask_left == '0) begin
            term_d  = T_ACK;
            state_d = DONE;
          end else begin
            cur_d = lowest(mask_left);
          end
        end
`ifdef WB_DS_TIMEOUT_EN
        else if (tmo_hit) begin
          term_d  = T_ERR;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      term_q  <= T_ACK;
      mask_q  <= '0;
      cur_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      if (load) begin
        base_q <= m_adr_i[ADDR_WIDTH-1:MLB];
        we_q   <= m_we_i;
        sel_q  <= m_sel_i;
        dat_q  <= m_dat_i;
        acc_q  <= '0;
      end
      if (beat_ack) begin
        acc_q[cur_q*SLV_DW +: SLV_DW] <= s_dat_i;
      end
    end
  end

  // Base has its low bits zero, so the lane offset can be concatenated in.
  assign lane_off = MLB'(cur_q) << SBL;
  assign s_adr_o  = {base_q, lane_off};
  assign s_dat_o  = dat_q[cur_q*SLV_DW +: SLV_DW];
  assign s_sel_o  = in_req ? sel_q[cur_q*SB +: SB] : '0;
  assign s_we_o   = in_req & we_q;
  assign s_cyc_o  = in_req & m_cyc_i;
  assign s_stb_o  = in_req & m_cyc_i;

  assign m_dat_o  = acc_q;
  assign m_ack_o  = (state_q == DONE) && (term_q == T_ACK);
  assign m_err_o  = (state_q == DONE) && (term_q == T_ERR);
  assign m_rty_o  = (state_q == DONE) && (term_q == T_RTY);

endmodule

// File: tb/tb_wb_width_downsizer.sv
// tb/tb_wb_width_downsizer.sv - Directed vector bench for wb_width_downsizer.
module tb_wb_width_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = '0;
  logic        m_stb = 1'b0;
  logic        m_cyc8 = 1'b0;
  logic        m_cyc16 = 1'b0;
  logic [1:0]  mode = 2'd0;

  logic [31:0] m_dat8, s_adr8;
  logic        m_ack8, m_err8, m_rty8, s_we8, s_cyc8, s_stb8;
  logic [7:0]  s_dat_o8, s_dat_i8;
  logic [0:0]  s_sel8;
  logic        s_ack8, s_err8, s_rty8;

  logic [31:0] m_dat16, s_adr16;
  logic        m_ack16, m_err16, m_rty16, s_we16, s_cyc16, s_stb16;
  logic [15:0] s_dat_o16, s_dat_i16;
  logic [1:0]  s_sel16;
  logic        s_ack16, s_err16, s_rty16;

  always #5 clk = ~clk;

  wb_width_downsizer #(.MST_DW(32), .SLV_DW(8), .ADDR_WIDTH(32), .TMO_CYCLES(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat8), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_cyc_i(m_cyc8), .m_stb_i(m_stb), .m_ack_o(m_ack8), .m_err_o(m_err8), .m_rty_o(m_rty8),
    .s_adr_o(s_adr8), .s_dat_o(s_dat_o8), .s_dat_i(s_dat_i8), .s_we_o(s_we8), .s_sel_o(s_sel8),
    .s_cyc_o(s_cyc8), .s_stb_o(s_stb8), .s_ack_i(s_ack8), .s_err_i(s_err8), .s_rty_i(s_rty8)
  );

  wb_width_downsizer #(.MST_DW(32), .SLV_DW(16), .ADDR_WIDTH(32), .TMO_CYCLES(8)) u_dut16 (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat16), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_cyc_i(m_cyc16), .m_stb_i(m_stb), .m_ack_o(m_ack16), .m_err_o(m_err16), .m_rty_o(m_rty16),
    .s_adr_o(s_adr16), .s_dat_o(s_dat_o16), .s_dat_i(s_dat_i16), .s_we_o(s_we16), .s_sel_o(s_sel16),
    .s_cyc_o(s_cyc16), .s_stb_o(s_stb16), .s_ack_i(s_ack16), .s_err_i(s_err16), .s_rty_i(s_rty16)
  );

  // Zero-wait slaves; mode 0 ack, 1 err, 2 rty, 3 never respond. Byte at addr a is {a+1,a+1} nibbles.
  assign s_dat_i8  = {s_adr8[3:0] + 4'd1, s_adr8[3:0] + 4'd1};
  assign s_ack8    = s_cyc8 & s_stb8 & (mode == 2'd0);
  assign s_err8    = s_cyc8 & s_stb8 & (mode == 2'd1);
  assign s_rty8    = s_cyc8 & s_stb8 & (mode == 2'd2);
  assign s_dat_i16 = 16'hBEEF;
  assign s_ack16   = s_cyc16 & s_stb16 & (mode == 2'd0);
  assign s_err16   = s_cyc16 & s_stb16 & (mode == 2'd1);
  assign s_rty16   = s_cyc16 & s_stb16 & (mode == 2'd2);

  logic [7:0]  nb8 = '0;
  logic [7:0]  nb16 = '0;
  logic [31:0] log_adr [0:255];
  logic [7:0]  log_dat [0:255];

  always @(posedge clk) begin
    if (s_cyc8 && s_stb8 && (s_ack8 || s_err8 || s_rty8)) begin
      log_adr[nb8] <= s_adr8;
      log_dat[nb8] <= s_we8 ? s_dat_o8 : s_dat_i8;
      nb8 <= nb8 + 8'd1;
    end
    if (s_cyc16 && s_stb16 && (s_ack16 || s_err16 || s_rty16)) begin
      nb16 <= nb16 + 8'd1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // got: 0 ack, 1 err, 2 rty, 3 nothing within the cycle budget.
  task automatic wait_term(input bit w16, output int got, output int lat, output logic [31:0] rdat);
    got = 3;
    lat = 0;
    rdat = '0;
    while (lat < 40 && got == 3) begin
      @(negedge clk);
      lat++;
      rdat = w16 ? m_dat16 : m_dat8;
      if (w16 ? m_ack16 : m_ack8) got = 0;
      else if (w16 ? m_err16 : m_err8) got = 1;
      else if (w16 ? m_rty16 : m_rty8) got = 2;
    end
  endtask

  task automatic start(input bit w16, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic [1:0] md);
    @(negedge clk);
    mode = md; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel; m_stb = 1'b1;
    if (w16) m_cyc16 = 1'b1; else m_cyc8 = 1'b1;
  endtask

  task automatic stop_master();
    m_cyc8 = 1'b0; m_cyc16 = 1'b0; m_stb = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [1:0]  mode;
    int          exp_term;
    int          exp_lat;
    int          exp_beats;
    logic [31:0] exp_rdat;
    logic [31:0] exp_fadr;
    logic [7:0]  exp_fdat;
    logic [31:0] exp_ladr;
    logic [7:0]  exp_ldat;
  } vec_t;

  vec_t vecs [0:9];

  task automatic run_vec(input int idx, input vec_t v);
    int got, lat, beats;
    logic [31:0] rdat;
    logic [7:0] base;
    string tag;
    tag = $sformatf("v%0d", idx);
    base = nb8;
    start(1'b0, v.we, v.adr, v.dat, v.sel, v.mode);
    wait_term(1'b0, got, lat, rdat);
    stop_master();
    beats = int'(8'(nb8 - base));
    chk({tag, "_term"}, 32'(got), 32'(v.exp_term));
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_beats"}, 32'(beats), 32'(v.exp_beats));
    if (!v.we && v.exp_term == 0) chk({tag, "_rdata"}, rdat, v.exp_rdat);
    if (v.exp_beats > 0) begin
      chk({tag, "_first_adr"}, log_adr[base], v.exp_fadr);
      chk({tag, "_first_dat"}, 32'(log_dat[base]), 32'(v.exp_fdat));
      chk({tag, "_last_adr"}, log_adr[8'(nb8 - 8'd1)], v.exp_ladr);
      chk({tag, "_last_dat"}, 32'(log_dat[8'(nb8 - 8'd1)]), 32'(v.exp_ldat));
    end
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'({m_ack8, m_err8, m_rty8}), 32'd0);
  endtask

  initial begin
    int got, lat;
    logic [31:0] rdat;
    logic [7:0] b16;
    logic seen;

    vecs[0] = '{we:0, adr:32'h1000, dat:0, sel:4'hF, mode:0, exp_term:0, exp_lat:5, exp_beats:4,
                exp_rdat:32'h44332211, exp_fadr:32'h1000, exp_fdat:8'h11, exp_ladr:32'h1003, exp_ldat:8'h44};
    vecs[1] = '{we:1, adr:32'h2000, dat:32'hAABBCCDD, sel:4'b0101, mode:0, exp_term:0, exp_lat:3, exp_beats:2,
                exp_rdat:0, exp_fadr:32'h2000, exp_fdat:8'hDD, exp_ladr:32'h2002, exp_ldat:8'hBB};
    vecs[2] = '{we:0, adr:32'h3000, dat:0, sel:4'h0, mode:0, exp_term:0, exp_lat:1, exp_beats:0,
                exp_rdat:0, exp_fadr:0, exp_fdat:0, exp_ladr:0, exp_ldat:0};
    vecs[3] = '{we:0, adr:32'h1000, dat:0, sel:4'b0101, mode:0, exp_term:0, exp_lat:3, exp_beats:2,
                exp_rdat:32'h00330011, exp_fadr:32'h1000, exp_fdat:8'h11, exp_ladr:32'h1002, exp_ldat:8'h33};
    vecs[4] = '{we:0, adr:32'h1006, dat:0, sel:4'b1000, mode:0, exp_term:0, exp_lat:2, exp_beats:1,
                exp_rdat:32'h88000000, exp_fadr:32'h1007, exp_fdat:8'h88, exp_ladr:32'h1007, exp_ldat:8'h88};
    vecs[5] = '{we:0, adr:32'h1000, dat:0, sel:4'hF, mode:2, exp_term:2, exp_lat:2, exp_beats:1,
                exp_rdat:0, exp_fadr:32'h1000, exp_fdat:8'h11, exp_ladr:32'h1000, exp_ldat:8'h11};
    vecs[6] = '{we:0, adr:32'h1000, dat:0, sel:4'b1100, mode:1, exp_term:1, exp_lat:2, exp_beats:1,
                exp_rdat:0, exp_fadr:32'h1002, exp_fdat:8'h33, exp_ladr:32'h1002, exp_ldat:8'h33};
    vecs[7] = '{we:1, adr:32'h1004, dat:32'h01020304, sel:4'hF, mode:0, exp_term:0, exp_lat:5, exp_beats:4,
                exp_rdat:0, exp_fadr:32'h1004, exp_fdat:8'h04, exp_ladr:32'h1007, exp_ldat:8'h01};
    vecs[8] = '{we:0, adr:32'h1004, dat:0, sel:4'hF, mode:0, exp_term:0, exp_lat:5, exp_beats:4,
                exp_rdat:32'h88776655, exp_fadr:32'h1004, exp_fdat:8'h55, exp_ladr:32'h1007, exp_ldat:8'h88};
    vecs[9] = '{we:0, adr:32'h100C, dat:0, sel:4'b0110, mode:0, exp_term:0, exp_lat:3, exp_beats:2,
                exp_rdat:32'h00FFEE00, exp_fadr:32'h100D, exp_fdat:8'hEE, exp_ladr:32'h100E, exp_ldat:8'hFF};

    repeat (3) @(negedge clk);
    chk("reset_ctrl_outs", 32'({m_ack8, m_err8, m_rty8, s_we8, s_cyc8, s_stb8, s_sel8}), 32'd0);
    chk("reset_m_dat", m_dat8, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-access forces outputs low at once.
    start(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, 2'd3);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_req_cyc", 32'(s_cyc8), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_ctrl_outs", 32'({m_ack8, m_err8, m_rty8, s_we8, s_cyc8, s_stb8, s_sel8}), 32'd0);
    chk("rst_s_adr", s_adr8, 32'd0);
    chk("rst_m_dat", m_dat8, 32'd0);
    @(negedge clk);
    stop_master();
    rst = 1'b1;
    run_vec(10, vecs[0]);

    // Master abandons the cycle during REQ.
    start(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, 2'd3);
    @(negedge clk);
    @(negedge clk);
    stop_master();
    #1;
    chk("drop_s_cyc", 32'({s_cyc8, s_stb8}), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | m_ack8 | m_err8 | m_rty8;
    end
    chk("drop_no_term", 32'(seen), 32'd0);
    run_vec(11, vecs[3]);

    // Back-to-back: strobe held after ack starts the next access.
    start(1'b0, 1'b0, 32'h1000, 32'h0, 4'b0001, 2'd0);
    wait_term(1'b0, got, lat, rdat);
    chk("b2b_first_rdata", rdat, 32'h00000011);
    m_adr = 32'h1004;
    wait_term(1'b0, got, lat, rdat);
    stop_master();
    chk("b2b_second_term", 32'(got), 32'd0);
    chk("b2b_second_latency", 32'(lat), 32'd3);
    chk("b2b_second_rdata", rdat, 32'h00000055);
    @(negedge clk);

    // 16-bit slave errors on the first beat.
    b16 = nb16;
    start(1'b1, 1'b0, 32'h4000, 32'h0, 4'hF, 2'd1);
    wait_term(1'b1, got, lat, rdat);
    stop_master();
    chk("err16_term", 32'(got), 32'd1);
    chk("err16_latency", 32'(lat), 32'd2);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | m_ack16 | s_cyc16;
    end
    chk("err16_no_ack_no_beat", 32'(seen), 32'd0);
    chk("err16_beats", 32'(8'(nb16 - b16)), 32'd1);

`ifdef WB_DS_TIMEOUT_EN
    start(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, 2'd3);
    wait_term(1'b0, got, lat, rdat);
    chk("tmo_term", 32'(got), 32'd1);
    chk("tmo_latency", 32'(lat), 32'd9);
    chk("tmo_s_cyc", 32'(s_cyc8), 32'd0);
    stop_master();
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
